// File: rtl/serial_full_subtractor_18ec068.sv
// Bit-serial a - b, LSB first, one full-subtractor cell reused per bit.
// Borrow is carried between bits in a flop; start/busy/done handshake.

module fs_cell_18ec068 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_full_subtractor_18ec068 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    fs_cell_18ec068 u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // New bit enters at the MSB so the LSB-first stream ends up aligned.
    assign res_next = {d, res[WIDTH-1:1]};

    // Control FSM with datapath shift and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            count      <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        res    <= '0;
                        borrow <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= res_next;
                    borrow <= bout;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        diff       <= res_next;
                        borrow_out <= bout;
                        overflow   <= (a_msb != b_msb) & (d != a_msb);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_full_subtractor_18ec068.sv
// Scoreboard bench: 8-bit directed vectors plus 4-bit exhaustive run.
// Expected results are queued at issue and popped on each done pulse.

module tb_serial_full_subtractor_18ec068;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bo8;
    logic       ov8;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bo4;
    logic       ov4;

    int checks = 0;
    int errors = 0;

    logic [9:0] q8[$];
    logic [5:0] q4[$];
    logic [9:0] exp8;
    logic [5:0] exp4;
    int         cyc4 = 0;
    int         last4 = -1;

    always #5 clk = ~clk;

    serial_full_subtractor_18ec068 #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .overflow   (ov8)
    );

    serial_full_subtractor_18ec068 #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bo4),
        .overflow   (ov4)
    );

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected got diff=%0d bo=%0b ov=%0b need no done",
                         diff8, bo8, ov8);
            end else begin
                exp8 = q8.pop_front();
                if ({diff8, bo8, ov8} !== exp8) begin
                    errors++;
                    $display("FAIL result8 got diff=%0d bo=%0b ov=%0b need diff=%0d bo=%0b ov=%0b",
                             diff8, bo8, ov8, exp8[9:2], exp8[1], exp8[0]);
                end
            end
        end
    end

    // Monitor for the 4-bit instance, including done spacing.
    always @(negedge clk) begin
        cyc4++;
        if (done4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL done4_unexpected got diff=%0d need no done", diff4);
            end else begin
                exp4 = q4.pop_front();
                if ({diff4, bo4, ov4} !== exp4) begin
                    errors++;
                    $display("FAIL result4 got diff=%0d bo=%0b ov=%0b need diff=%0d bo=%0b ov=%0b",
                             diff4, bo4, ov4, exp4[5:2], exp4[1], exp4[0]);
                end
            end
            if (last4 >= 0) begin
                checks++;
                if (cyc4 - last4 != 6) begin
                    errors++;
                    $display("FAIL done4_gap got %0d need 6", cyc4 - last4);
                end
            end
            last4 = cyc4;
        end
    end

    task automatic check(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s got %0d need %0d", name, got, need);
        end
    endtask

    task automatic wait_idle8();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy8 || done8) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("idle8_timeout", int'(busy8 || done8), 0);
    endtask

    // Issue one 8-bit op, check latency and busy length.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic bo, input logic ov);
        int n;
        int nb;
        wait_idle8();
        q8.push_back({d, bo, ov});
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        @(posedge clk);
        n = 0;
        nb = 0;
        while (n < 30) begin
            @(negedge clk);
            start8 = 1'b0;
            n++;
            if (busy8) nb++;
            if (done8) break;
        end
        check("latency8", n, 9);
        check("busy_len8", nb, 8);
    endtask

    initial begin
        int nd;
        int k;
        int sa;
        int sb;
        int r;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       got;
        logic       prev;

        repeat (3) @(negedge clk);
        check("rst_state8", int'({busy8, done8, diff8, bo8, ov8}), 0);
        check("rst_state4", int'({busy4, done4, diff4, bo4, ov4}), 0);
        rst = 1'b0;

        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
        run_op(8'd5, 8'd9, 8'd252, 1'b1, 1'b0);
        run_op(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        run_op(8'd255, 8'd255, 8'd0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start and operand changes during busy must be ignored
        wait_idle8();
        q8.push_back({8'd30, 1'b0, 1'b0});
        a8 = 8'd50;
        b8 = 8'd20;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'd1;
        b8 = 8'd2;
        @(negedge clk);
        a8 = 8'd77;
        b8 = 8'd5;
        @(negedge clk);
        start8 = 1'b0;
        nd = 0;
        repeat (16) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("single_done8", nd, 1);

        // reset in the middle of SHIFT discards the operation
        wait_idle8();
        a8 = 8'd200;
        b8 = 8'd1;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", int'(busy8), 0);
        check("rst_mid_done", int'(done8), 0);
        check("rst_mid_diff", int'(diff8), 0);
        nd = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("rst_no_done", nd, 0);
        run_op(8'd9, 8'd3, 8'd6, 1'b0, 1'b0);

        // exhaustive 4-bit run with start held high
        prev = busy4;
        start4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ea = 4'(i >> 4);
            eb = 4'(i & 15);
            sa = (ea >= 8) ? int'(ea) - 16 : int'(ea);
            sb = (eb >= 8) ? int'(eb) - 16 : int'(eb);
            r = sa - sb;
            q4.push_back({4'((int'(ea) - int'(eb)) & 15), ea < eb,
                          (r < -8) || (r > 7)});
            a4 = ea;
            b4 = eb;
            got = 1'b0;
            for (int j = 0; j < 20 && !got; j++) begin
                @(negedge clk);
                if (busy4 && !prev) got = 1'b1;
                prev = busy4;
            end
            if (!got) begin
                check("accept4_timeout", 0, 1);
                break;
            end
        end
        start4 = 1'b0;
        k = 0;
        while (q4.size() > 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("q4_drained", q4.size(), 0);
        check("q8_drained", q8.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_full_subtractor_18ec068.md
Name: serial_full_subtractor_18ec068

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Each bit is computed by one full-subtractor cell (difference and borrow), with the borrow held in a flip-flop between bits.
- Complements the team's combinational full-adder blocks: the subtract direction of the same arithmetic, time-multiplexed onto a single cell behind a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; latched when start is accepted
- b  input  WIDTH  subtrahend; latched when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  result a - b, modulo 2^WIDTH
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned)
- overflow  output  1  signed overflow of a - b (two's complement)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state becomes IDLE.
  - busy, done, diff, borrow_out and overflow become 0.
  - Internal shift registers, bit counter and borrow flop are cleared.
  - Reset has priority over every other event, including mid-operation; a partial result is discarded and done never pulses.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0; diff, borrow_out and overflow hold their last values.
  - On an edge with start=1: latch a into sa and b into sb, set borrow=0 and count=0, go to SHIFT.
- SHIFT (busy=1), at each edge:
  - x=sa[0], y=sb[0], bin=borrow.
  - d = x^y^bin.
  - bout = (~x&y) | (~(x^y)&bin).
  - Shift sa and sb right by one.
  - Shift the result register right, inserting d at the MSB.
  - borrow <= bout; count <= count+1.
  - When count==WIDTH-1 at the edge, go to DONE after that edge.
- Leaving SHIFT (same edge):
  - diff <= the final result register, including the last bit.
  - borrow_out <= final bout.
  - overflow <= (a_msb != b_msb) & (diff_msb != a_msb), using the latched operand MSBs.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE on the next edge unconditionally.
- Latency: start accepted at edge E0 → busy high for cycles after E0..E(WIDTH−1) → done high in the cycle after edge E(WIDTH). Total WIDTH+1 cycles from acceptance to the done pulse.
- start while busy, or in DONE: ignored, with no effect on the operation in progress. start held high continuously gives back-to-back operations, one every WIDTH+2 cycles.
- a and b may change freely after acceptance; only the latched copies are used.
- diff, borrow_out and overflow are registered, stable from the done cycle until the next accepted start completes.
- Counter width: $clog2(WIDTH)+1 bits; no wrap beyond WIDTH.
- Cell implementation: structural instantiation of a one-bit full-subtractor cell is preferred; an equivalent dataflow expression is acceptable.

Test Plan:
- WIDTH=8, a=100, b=37, pulse start → done exactly 9 cycles after the acceptance edge; diff=63, borrow_out=0, overflow=0; busy high for 8 cycles.
- a=5, b=9 → diff=8'd252, borrow_out=1, overflow=0; a=0, b=0 → diff=0, borrow_out=0; a=255, b=255 → diff=0, borrow_out=0.
- a=8'h80, b=8'h01 → diff=8'h7F, overflow=1, borrow_out=0; a=8'h7F, b=8'hFF → diff=8'h80, overflow=1, borrow_out=1.
- Start a=50, b=20; pulse start with a=1, b=2 at cycle 3 of busy and change a/b mid-operation → single done, diff=30; no second operation starts.
- Assert rst at cycle 4 of SHIFT → the following cycle has busy=0, done=0, diff=0; no done pulse appears; a new start then computes a=9, b=3 → diff=6.
- Exhaustive run at WIDTH=4 over all 256 (a,b) pairs, with start held high → each result matches (a-b) mod 16, borrow=(a<b) and signed overflow; done pulses are exactly 6 cycles apart.
